// File: rtl/esm_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : esm_slot_allocator
// Brief    : Shuffle-buffer slot allocator. Hands out the lowest free slot,
//            offers it to the shuffle core, and reclaims returned slots.
// Revision : 1.0 - initial release
// ============================================================================
module esm_slot_allocator #(
    parameter int BS = 16,
    parameter int IW = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          alloc_valid,
    output logic [IW-1:0] alloc_index,
    input  logic          alloc_ack,
    input  logic          rel_valid,
    input  logic [IW-1:0] rel_index,
    output logic [IW:0]   occupancy,
    output logic          full,
    output logic          empty,
    output logic          err_dbl_free
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [IW:0] c_OCC_FULL = (IW+1)'(BS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BS-1:0]   r_bitmap;
    logic [BS-1:0]   w_bitmap_nxt;
    logic [BS-1:0]   w_alloc_mask;
    logic [BS-1:0]   w_rel_mask;
    logic [IW:0]     r_occupancy;
    logic [IW:0]     w_occ_nxt;
    logic [IW-1:0]   r_alloc_index;
    logic [IW-1:0]   w_free_idx;
    logic            r_run;
    logic            r_err;
    logic            w_accept;
    logic            w_rel_legal;
    logic            w_rel_bad;

    // r_run keeps in_ready low while reset is held and for the reset cycle itself
    assign full        = (r_occupancy == c_OCC_FULL);
    assign empty       = (r_occupancy == '0);
    assign in_ready    = r_run && (r_state == ST_IDLE) && !full;
    assign alloc_valid = (r_state == ST_OFFER);
    assign alloc_index = r_alloc_index;
    assign occupancy   = r_occupancy;
    assign err_dbl_free = r_err;

    assign w_accept    = in_valid && in_ready;
    assign w_rel_legal = rel_valid && r_bitmap[rel_index];
    assign w_rel_bad   = rel_valid && !r_bitmap[rel_index];

    // Priority search from the top down so the lowest free index wins
    always_comb begin
        w_free_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!r_bitmap[i]) begin
                w_free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_alloc_mask = '0;
        w_rel_mask   = '0;
        if (w_accept) begin
            w_alloc_mask = BS'(1) << w_free_idx;
        end
        if (w_rel_legal) begin
            w_rel_mask = BS'(1) << rel_index;
        end
        w_bitmap_nxt = (r_bitmap | w_alloc_mask) & ~w_rel_mask;
    end

    always_comb begin
        w_occ_nxt = r_occupancy;
        case ({w_accept, w_rel_legal})
            2'b10:   w_occ_nxt = r_occupancy + (IW+1)'(1);
            2'b01:   w_occ_nxt = r_occupancy - (IW+1)'(1);
            default: w_occ_nxt = r_occupancy;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_state_nxt = ST_OFFER;
            ST_OFFER: if (alloc_ack) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bitmap      <= '0;
            r_occupancy   <= '0;
            r_alloc_index <= '0;
            r_run         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitmap    <= w_bitmap_nxt;
            r_occupancy <= w_occ_nxt;
            r_run       <= 1'b1;
            if (w_accept) begin
                r_alloc_index <= w_free_idx;
            end
            if (w_rel_bad) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esm_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_esm_slot_allocator
// Brief    : Directed self-checking bench for esm_slot_allocator (BS = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_esm_slot_allocator;

    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          alloc_valid;
    logic [IW-1:0] alloc_index;
    logic          alloc_ack;
    logic          rel_valid;
    logic [IW-1:0] rel_index;
    logic [IW:0]   occupancy;
    logic          full;
    logic          empty;
    logic          err_dbl_free;

    int checks = 0;
    int errors = 0;

    esm_slot_allocator #(.BS(BS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alloc_valid  (alloc_valid),
        .alloc_index  (alloc_index),
        .alloc_ack    (alloc_ack),
        .rel_valid    (rel_valid),
        .rel_index    (rel_index),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty),
        .err_dbl_free (err_dbl_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Allocate one slot with an immediate acknowledge; ends back in IDLE
    task automatic alloc_one();
        in_valid  = 1'b1;
        alloc_ack = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; alloc_ack = 1'b0; rel_valid = 1'b0; rel_index = '0;
        repeat (2) step();
        checks++;
        if (in_ready !== 1'b0 || alloc_valid !== 1'b0 || occupancy !== 5'd0 ||
            empty !== 1'b1 || full !== 1'b0 || err_dbl_free !== 1'b0 || alloc_index !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b av=%b idx=%0d occ=%0d empty=%b full=%b err=%b, required 0 0 0 0 1 0 0",
                     in_ready, alloc_valid, alloc_index, occupancy, empty, full, err_dbl_free);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_fill();
        in_valid  = 1'b1;
        alloc_ack = 1'b1;
        for (int n = 0; n < BS; n++) begin
            step();
            checks++;
            if (alloc_valid !== 1'b1 || alloc_index !== IW'(n)) begin
                errors++;
                $display("FAIL fill_index: av=%b idx=%0d, required 1 %0d", alloc_valid, alloc_index, n);
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || occupancy !== 5'd16 || alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b rdy=%b occ=%0d av=%b, required 1 0 16 0",
                     full, in_ready, occupancy, alloc_valid);
        end
    endtask

    task automatic test_release_reuse();
        rel_valid = 1'b1;
        rel_index = 4'd5;
        step();
        rel_valid = 1'b0;
        checks++;
        if (occupancy !== 5'd15 || full !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_occ: occ=%0d full=%b rdy=%b, required 15 0 1", occupancy, full, in_ready);
        end
        in_valid  = 1'b1;
        alloc_ack = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_index !== 4'd5 || occupancy !== 5'd16) begin
            errors++;
            $display("FAIL reuse_index: av=%b idx=%0d occ=%0d, required 1 5 16", alloc_valid, alloc_index, occupancy);
        end
        alloc_ack = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        repeat (3) alloc_one();
        checks++;
        if (occupancy !== 5'd3) begin
            errors++;
            $display("FAIL simul_setup_occ: occ=%0d, required 3", occupancy);
        end
        in_valid  = 1'b1;
        alloc_ack = 1'b1;
        rel_valid = 1'b1;
        rel_index = 4'd1;
        step();
        in_valid  = 1'b0;
        rel_valid = 1'b0;
        checks++;
        if (alloc_index !== 4'd3 || occupancy !== 5'd3 || dut.r_bitmap !== 16'h000D) begin
            errors++;
            $display("FAIL simul_update: idx=%0d occ=%0d bitmap=%h, required 3 3 000d",
                     alloc_index, occupancy, dut.r_bitmap);
        end
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (alloc_index !== 4'd1 || occupancy !== 5'd4) begin
            errors++;
            $display("FAIL simul_refill: idx=%0d occ=%0d, required 1 4", alloc_index, occupancy);
        end
        step();
    endtask

    task automatic test_double_free();
        rel_valid = 1'b1;
        rel_index = 4'd7;
        step();
        rel_valid = 1'b0;
        checks++;
        if (err_dbl_free !== 1'b1 || occupancy !== 5'd4) begin
            errors++;
            $display("FAIL dbl_free_flag: err=%b occ=%0d, required 1 4", err_dbl_free, occupancy);
        end
        repeat (3) step();
        checks++;
        if (err_dbl_free !== 1'b1 || occupancy !== 5'd4) begin
            errors++;
            $display("FAIL dbl_free_sticky: err=%b occ=%0d, required 1 4", err_dbl_free, occupancy);
        end
    endtask

    task automatic test_backpressure();
        // acknowledge seen in IDLE must not disturb anything
        in_valid  = 1'b0;
        alloc_ack = 1'b1;
        step();
        checks++;
        if (alloc_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ack_ignored: av=%b rdy=%b, required 0 1", alloc_valid, in_ready);
        end
        alloc_ack = 1'b0;
        in_valid  = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (alloc_valid !== 1'b1 || alloc_index !== 4'd4 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d av=%b idx=%0d rdy=%b, required 1 4 0",
                         c, alloc_valid, alloc_index, in_ready);
            end
            step();
        end
        in_valid  = 1'b0;
        alloc_ack = 1'b1;
        step();
        alloc_ack = 1'b0;
        checks++;
        if (alloc_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 5'd5) begin
            errors++;
            $display("FAIL backpressure_release: av=%b rdy=%b occ=%0d, required 0 1 5",
                     alloc_valid, in_ready, occupancy);
        end
    endtask

    task automatic test_reset_mid_offer();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_index !== 4'd5) begin
            errors++;
            $display("FAIL offer_before_reset: av=%b idx=%0d, required 1 5", alloc_valid, alloc_index);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (alloc_valid !== 1'b0 || occupancy !== 5'd0 || empty !== 1'b1 ||
            err_dbl_free !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: av=%b occ=%0d empty=%b err=%b rdy=%b, required 0 0 1 0 0",
                     alloc_valid, occupancy, empty, err_dbl_free, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        in_valid  = 1'b1;
        alloc_ack = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_index !== 4'd0 || occupancy !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_alloc: av=%b idx=%0d occ=%0d, required 1 0 1",
                     alloc_valid, alloc_index, occupancy);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_reuse();
        test_simultaneous();
        test_double_free();
        test_backpressure();
        test_reset_mid_offer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esm_slot_allocator.md
ESM_SLOT_ALLOCATOR -- requirements
Module: esm_slot_allocator

Interface
REQ-001 The block SHALL have parameter BS, default 16: number of shuffle-buffer slots; power of two, minimum 2.
REQ-002 The block SHALL have derived parameter IW, default $clog2(BS): slot index width.
REQ-003 The block SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1: upstream has an element to write into the buffer.
REQ-006 The block SHALL have port in_ready, output, 1: allocator accepts an element this cycle.
REQ-007 The block SHALL have port alloc_valid, output, 1: alloc_index is offered to the shuffle core as a newly ready slot.
REQ-008 The block SHALL have port alloc_index, output, IW: slot assigned to the accepted element.
REQ-009 The block SHALL have port alloc_ack, input, 1: shuffle core has taken alloc_index.
REQ-010 The block SHALL have port rel_valid, input, 1: shuffle core has emitted a slot, which is returned for reuse.
REQ-011 The block SHALL have port rel_index, input, IW: slot being returned.
REQ-012 The block SHALL have port occupancy, output, IW+1: number of occupied slots, range 0..BS.
REQ-013 The block SHALL have port full, output, 1: occupancy == BS.
REQ-014 The block SHALL have port empty, output, 1: occupancy == 0.
REQ-015 The block SHALL have port err_dbl_free, output, 1: sticky flag; a release targeted a free slot.

Function
REQ-016 The block SHALL hold a BS-bit occupancy bitmap, where 1 = occupied.
REQ-017 The block SHALL keep the occupancy counter equal to popcount(bitmap) at every cycle boundary.
REQ-018 The block SHALL implement a two-state FSM: IDLE and OFFER.
REQ-019 The block SHALL drive in_ready = (state == IDLE) && !full, combinationally from registered state only; it SHALL NOT depend on in_valid.
REQ-020 In IDLE, when in_valid && in_ready, the block SHALL on that edge: set the bitmap bit of the lowest-numbered free slot, register that index into alloc_index, and move to OFFER.
REQ-021 The block SHALL drive alloc_valid = (state == OFFER); alloc_valid is therefore first high one cycle after acceptance.
REQ-022 In OFFER, alloc_index and alloc_valid SHALL hold stable until alloc_ack is sampled high; on that edge the block SHALL return to IDLE.
REQ-023 The block SHALL ignore alloc_ack in IDLE.
REQ-024 A single accepted element SHALL yield exactly one alloc_valid/alloc_ack transaction; the minimum accept-to-accept period is 2 cycles.
REQ-025 Lowest-free selection SHALL use the bitmap value before any same-cycle release; a slot released on edge N SHALL NOT be allocated before edge N+1.
REQ-026 The block SHALL process rel_valid in any state, independent of the FSM.
REQ-027 When rel_valid is high and bitmap[rel_index] == 1, the block SHALL clear that bit on the edge.
REQ-028 When rel_valid is high and bitmap[rel_index] == 0, the block SHALL leave the bitmap unchanged and set err_dbl_free; err_dbl_free SHALL clear only on rst.
REQ-029 A release of the slot currently offered in OFFER SHALL be treated as a legal release; the offer SHALL continue until alloc_ack.
REQ-030 On a simultaneous allocation and legal release on the same edge, occupancy SHALL be unchanged and both bitmap updates SHALL apply.
REQ-031 occupancy SHALL increment on allocation only, decrement on legal release only, and never wrap.
REQ-032 full and empty SHALL be registered-state decodes of occupancy, valid in the same cycle as occupancy.

Reset
REQ-033 While rst is high, the block SHALL hold: bitmap = 0, occupancy = 0, state = IDLE, alloc_valid = 0, alloc_index = 0, err_dbl_free = 0, empty = 1, full = 0, in_ready = 0.
REQ-034 On the first rising clk edge after rst deasserts, the block SHALL drive in_ready = 1.
REQ-035 An rst assertion in OFFER SHALL drop alloc_valid asynchronously, discard the pending offer and free all slots.

Verification
REQ-036 Scenario, fill: BS=16, alloc_ack tied high, in_valid held high -> alloc_index sequence 0,1,...,15 on alternate cycles; full=1 and in_ready=0 after the 16th acceptance; occupancy=16.
REQ-037 Scenario, release and reuse: from full, release slot 5 -> occupancy=15, full=0; next acceptance yields alloc_index=5.
REQ-038 Scenario, simultaneous events: occupancy=3 (slots 0-2), accept and release slot 1 on the same edge -> alloc_index=3, occupancy=3, bitmap=0b1101.
REQ-039 Scenario, double free: release slot 7 while free -> err_dbl_free=1 from the next cycle and stays set; occupancy unchanged.
REQ-040 Scenario, backpressure: alloc_ack held low for 5 cycles -> alloc_valid and alloc_index stable for 5 cycles, in_ready=0 throughout; alloc_ack=1 -> IDLE next cycle.
REQ-041 Scenario, reset mid-offer: assert rst asynchronously during OFFER -> alloc_valid=0 immediately, occupancy=0, empty=1; the first post-reset allocation yields index 0.
